// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: owns the architectural HI/LO registers,
// runs mult/multu/div/divu over a fixed busy window and serves mfhi/mflo reads.
module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp_E,
    input  logic        Start_E,
    input  logic [31:0] A_E,
    input  logic [31:0] B_E,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] MDdata_E
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   hi_tmp;
    logic [31:0]   lo_tmp;
    logic [CW-1:0] counter;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        div_b;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [31:0]        hi_next;
    logic [31:0]        lo_next;
    logic               is_md_op;

    assign prod_s = $signed({{32{A_E[31]}}, A_E}) * $signed({{32{B_E[31]}}, B_E});
    assign prod_u = {32'd0, A_E} * {32'd0, B_E};

    // The divider never sees a zero or overflowing divisor; those cases are
    // resolved separately, so a harmless substitute keeps the datapath defined.
    assign div_zero = (B_E == 32'd0);
    assign div_ovf  = (A_E == 32'h8000_0000) && (B_E == 32'hFFFF_FFFF);
    assign div_b    = (div_zero || div_ovf) ? 32'd1 : B_E;
    assign quo_s    = $signed(A_E) / $signed(div_b);
    assign rem_s    = $signed(A_E) % $signed(div_b);
    assign quo_u    = A_E / div_b;
    assign rem_u    = A_E % div_b;

    assign is_md_op = (MDOp_E == OP_MULT) || (MDOp_E == OP_MULTU) ||
                      (MDOp_E == OP_DIV)  || (MDOp_E == OP_DIVU);

    // Result to park in hi_tmp/lo_tmp at accept; divide by zero re-parks the
    // current HI/LO so completion leaves them unchanged.
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        case (MDOp_E)
            OP_MULT:  {hi_next, lo_next} = prod_s;
            OP_MULTU: {hi_next, lo_next} = prod_u;
            OP_DIV: begin
                if (div_zero) begin
                    hi_next = hi;
                    lo_next = lo;
                end else if (div_ovf) begin
                    hi_next = 32'd0;
                    lo_next = 32'h8000_0000;
                end else begin
                    hi_next = rem_s;
                    lo_next = quo_s;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    hi_next = rem_u;
                    lo_next = quo_u;
                end
            end
            default: ;
        endcase
    end

    // HI/LO state, busy window countdown and mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_tmp  <= 32'd0;
            lo_tmp  <= 32'd0;
            counter <= '0;
            Busy    <= 1'b0;
        end else if (Busy) begin
            // An in-flight op belongs to a committed instruction; Req does not abort it.
            if (counter == CW'(1)) begin
                hi      <= hi_tmp;
                lo      <= lo_tmp;
                counter <= '0;
                Busy    <= 1'b0;
            end else begin
                counter <= counter - CW'(1);
            end
        end else if (!Req) begin
            if (Start_E && is_md_op) begin
                hi_tmp  <= hi_next;
                lo_tmp  <= lo_next;
                counter <= ((MDOp_E == OP_MULT) || (MDOp_E == OP_MULTU)) ?
                           CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                Busy    <= 1'b1;
            end else if (MDOp_E == OP_MTHI) begin
                hi <= A_E;
            end else if (MDOp_E == OP_MTLO) begin
                lo <= A_E;
            end
        end
    end

    // Read port sees only committed HI/LO; stalls cover in-flight results.
    always_comb begin
        case (MDOp_E)
            OP_MFHI: MDdata_E = hi;
            OP_MFLO: MDdata_E = lo;
            default: MDdata_E = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: busy-window length, HI/LO results, Req and reset handling.
module tb_mdu_e;

    logic        clk;
    logic        reset;
    logic [3:0]  MDOp_E;
    logic        Start_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        Req;
    logic        Busy;
    logic [31:0] MDdata_E;

    int errors = 0;
    int checks = 0;

    mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .MDOp_E(MDOp_E),
        .Start_E(Start_E),
        .A_E(A_E),
        .B_E(B_E),
        .Req(Req),
        .Busy(Busy),
        .MDdata_E(MDdata_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction for a single edge, starting and ending on a negedge.
    task automatic issue(input logic [3:0] op, input logic start, input logic [31:0] a,
                         input logic [31:0] b, input logic req);
        MDOp_E  = op;
        Start_E = start;
        A_E     = a;
        B_E     = b;
        Req     = req;
        @(negedge clk);
        MDOp_E  = 4'd0;
        Start_E = 1'b0;
        A_E     = 32'd0;
        B_E     = 32'd0;
        Req     = 1'b0;
    endtask

    // Count busy cycles (sampled on negedges); optionally pulse Req or reset in cycle k.
    task automatic run_busy(input int req_cyc, input int rst_cyc, output int n);
        n = 0;
        while (Busy === 1'b1 && n < 50) begin
            n++;
            Req   = (n == req_cyc);
            reset = (n == rst_cyc);
            @(negedge clk);
        end
        Req   = 1'b0;
        reset = 1'b0;
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        MDOp_E = 4'd5;
        #1 h = MDdata_E;
        MDOp_E = 4'd6;
        #1 l = MDdata_E;
        MDOp_E = 4'd0;
    endtask

    logic [31:0] h, l;
    int n;

    initial begin
        reset = 1'b1; MDOp_E = 4'd0; Start_E = 1'b0; A_E = 32'd0; B_E = 32'd0; Req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        read_hilo(h, l);
        chk("reset_hi", h, 32'h0);
        chk("reset_lo", l, 32'h0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);

        // mult -1 * 2
        issue(4'd1, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b0);
        run_busy(0, 0, n);
        chk("mult_cycles", n, 32'd5);
        read_hilo(h, l);
        chk("mult_hi", h, 32'hFFFF_FFFF);
        chk("mult_lo", l, 32'hFFFF_FFFE);

        // multu 0xFFFFFFFF * 2
        issue(4'd2, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b0);
        run_busy(0, 0, n);
        chk("multu_cycles", n, 32'd5);
        read_hilo(h, l);
        chk("multu_hi", h, 32'h0000_0001);
        chk("multu_lo", l, 32'hFFFF_FFFE);

        // mult most-negative squared = 2^62
        issue(4'd1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_busy(0, 0, n);
        read_hilo(h, l);
        chk("mult_min_hi", h, 32'h4000_0000);
        chk("mult_min_lo", l, 32'h0000_0000);

        // div -7 / 2
        issue(4'd3, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0);
        run_busy(0, 0, n);
        chk("div_cycles", n, 32'd10);
        read_hilo(h, l);
        chk("div_hi", h, 32'hFFFF_FFFF);
        chk("div_lo", l, 32'hFFFF_FFFD);

        // divu 7 / 2
        issue(4'd4, 1'b1, 32'h7, 32'h2, 1'b0);
        run_busy(0, 0, n);
        chk("divu_cycles", n, 32'd10);
        read_hilo(h, l);
        chk("divu_hi", h, 32'h1);
        chk("divu_lo", l, 32'h3);

        // div overflow case
        issue(4'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_busy(0, 0, n);
        read_hilo(h, l);
        chk("div_ovf_hi", h, 32'h0);
        chk("div_ovf_lo", l, 32'h8000_0000);

        // mthi/mtlo then divide by zero
        issue(4'd7, 1'b0, 32'h1111_1111, 32'h0, 1'b0);
        issue(4'd8, 1'b0, 32'h2222_2222, 32'h0, 1'b0);
        read_hilo(h, l);
        chk("mthi_hi", h, 32'h1111_1111);
        chk("mtlo_lo", l, 32'h2222_2222);
        issue(4'd4, 1'b1, 32'h5, 32'h0, 1'b0);
        run_busy(0, 0, n);
        chk("divz_cycles", n, 32'd10);
        read_hilo(h, l);
        chk("divz_hi", h, 32'h1111_1111);
        chk("divz_lo", l, 32'h2222_2222);

        // Req blocks a start and an mtlo
        issue(4'd1, 1'b1, 32'h3, 32'h4, 1'b1);
        chk("req_start_busy", {31'd0, Busy}, 32'd0);
        issue(4'd8, 1'b0, 32'h5, 32'h0, 1'b1);
        read_hilo(h, l);
        chk("req_hi", h, 32'h1111_1111);
        chk("req_lo", l, 32'h2222_2222);

        // Req during busy does not abort
        issue(4'd1, 1'b1, 32'h3, 32'h4, 1'b0);
        run_busy(2, 0, n);
        chk("req_busy_cycles", n, 32'd5);
        read_hilo(h, l);
        chk("req_busy_hi", h, 32'h0);
        chk("req_busy_lo", l, 32'hC);

        // Unused opcodes read zero
        MDOp_E = 4'd0;
        #1 chk("rd_none", MDdata_E, 32'h0);
        MDOp_E = 4'd9;
        #1 chk("rd_op9", MDdata_E, 32'h0);
        MDOp_E = 4'd0;
        @(negedge clk);

        // Reset mid-divide
        issue(4'd7, 1'b0, 32'hAAAA_5555, 32'h0, 1'b0);
        issue(4'd3, 1'b1, 32'd100, 32'd7, 1'b0);
        run_busy(0, 4, n);
        chk("rst_mid_cycles", n, 32'd4);
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        read_hilo(h, l);
        chk("rst_mid_hi", h, 32'h0);
        chk("rst_mid_lo", l, 32'h0);
        repeat (12) @(negedge clk);
        read_hilo(h, l);
        chk("rst_late_hi", h, 32'h0);
        chk("rst_late_lo", l, 32'h0);
        chk("rst_late_busy", {31'd0, Busy}, 32'd0);

        // mthi after reset
        issue(4'd7, 1'b0, 32'hCAFE_BABE, 32'h0, 1'b0);
        read_hilo(h, l);
        chk("mthi_final", h, 32'hCAFE_BABE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
